// File: rtl/nco_clken_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel
// on refclk, with shadowed increment updates applied at wrap for glitch-free rate changes.
module nco_clken_gen #(
    parameter int              NUM_CH      = 2,
    parameter int              ACC_W       = 32,
    parameter int              CH_W        = 3,
    parameter logic [ACC_W-1:0] INC_RESET  = ACC_W'(32'd614961148),
    parameter int              LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              sync,
    output logic [NUM_CH-1:0] clken,
    output logic [NUM_CH-1:0] clkout,
    output logic              locked
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    logic [ACC_W-1:0]  acc    [NUM_CH];
    logic [ACC_W-1:0]  inc_q  [NUM_CH];
    logic [ACC_W-1:0]  shadow [NUM_CH];
    logic [ACC_W-1:0]  sum    [NUM_CH];
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] pending;
    logic              rdy_q;
    logic              accept;
    logic              any_hit;
    logic [LCW-1:0]    lock_cnt;

    assign cfg_ready = rdy_q & ~(|pending);

    always_comb begin
        accept = cfg_valid & cfg_ready;
        carry  = '0;
        hit    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            {carry[i], sum[i]} = {1'b0, acc[i]} + {1'b0, inc_q[i]};
            // Out-of-range cfg_ch matches no channel, so the request is swallowed.
            hit[i] = accept && (cfg_ch == CH_W'(i));
        end
        any_hit = |hit;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            pending  <= '0;
            clken    <= '0;
            clkout   <= '0;
            locked   <= 1'b0;
            lock_cnt <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i]    <= '0;
                inc_q[i]  <= INC_RESET;
                shadow[i] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sync) begin
                    acc[i]     <= '0;
                    clken[i]   <= 1'b0;
                    clkout[i]  <= 1'b0;
                    pending[i] <= 1'b0;
                    if (hit[i])
                        inc_q[i] <= cfg_inc;
                    else if (pending[i])
                        inc_q[i] <= shadow[i];
                end else begin
                    acc[i]    <= sum[i];
                    clken[i]  <= carry[i];
                    clkout[i] <= sum[i][ACC_W-1];
                    // Swap on the wrapping edge so the new rate starts from a fresh period;
                    // a frozen channel never wraps, so it swaps straight away.
                    if (hit[i]) begin
                        shadow[i]  <= cfg_inc;
                        pending[i] <= 1'b1;
                    end else if (pending[i] && (carry[i] || inc_q[i] == '0)) begin
                        inc_q[i]   <= shadow[i];
                        pending[i] <= 1'b0;
                    end
                end
            end

            if (sync || any_hit || (|pending))
                lock_cnt <= '0;
            else if (lock_cnt != LCW'(LOCK_CYCLES))
                lock_cnt <= lock_cnt + LCW'(1);
            locked <= (lock_cnt == LCW'(LOCK_CYCLES));
        end
    end

endmodule

// File: tb/tb_nco_clken_gen.sv
// Directed bench for nco_clken_gen at ACC_W=8, two channels, reset increment 64, short lock window.
module tb_nco_clken_gen;

    localparam int NUM_CH = 2;
    localparam int ACC_W  = 8;
    localparam int CH_W   = 3;
    localparam int LOCK   = 16;

    logic              refclk    = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [ACC_W-1:0]  cfg_inc   = '0;
    logic              sync      = 1'b0;
    logic [NUM_CH-1:0] clken;
    logic [NUM_CH-1:0] clkout;
    logic              locked;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int at;

    nco_clken_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .CH_W        (CH_W),
        .INC_RESET   (8'd64),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .sync      (sync),
        .clken     (clken),
        .clkout    (clkout),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic cfg(input int ch, input int val);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_inc   = ACC_W'(val);
        tick;
        cfg_valid = 1'b0;
    endtask

    task automatic first_pulse(input int ch, input int limit, output int pos);
        pos = 0;
        while (cyc < limit && pos == 0) begin
            tick;
            if (clken[ch]) pos = cyc;
        end
    endtask

    task automatic reset_and_lock(input string tag);
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        sync      = 1'b0;
        repeat (3) tick;
        check({tag, " rst ready"},  cfg_ready, 0);
        check({tag, " rst clken"},  clken,     0);
        check({tag, " rst clkout"}, clkout,    0);
        check({tag, " rst locked"}, locked,    0);
        rst_n = 1'b1;
        cyc   = 0;
        for (int t = 1; t <= 20; t++) begin
            tick;
            check($sformatf("%s clken c%0d", tag, t), clken, (t % 4 == 0) ? 3 : 0);
            if (t == 1)  check({tag, " ready rise"},  cfg_ready, 1);
            if (t == 2)  check({tag, " clkout high"}, clkout,    3);
            if (t == 16) check({tag, " lock early"},  locked,    0);
            if (t == 17) check({tag, " lock rise"},   locked,    1);
        end
    endtask

    initial begin
        reset_and_lock("por");

        // Rate change 64 -> 32 on ch0, requested mid-period.
        tick;
        cfg(0, 32);
        check("pend ready", cfg_ready, 0);
        check("pend lock held", locked, 1);
        tick;
        check("pend ready2", cfg_ready, 0);
        check("pend lock fall", locked, 0);
        tick;
        check("apply clken", clken, 3);
        check("apply ready", cfg_ready, 1);
        for (int t = 25; t <= 41; t++) begin
            tick;
            check($sformatf("ch0 inc32 c%0d", t), clken[0], (t == 32 || t == 40) ? 1 : 0);
            check($sformatf("ch1 inc64 c%0d", t), clken[1], (t % 4 == 0) ? 1 : 0);
            if (t == 40) check("relock early", locked, 0);
            if (t == 41) check("relock rise", locked, 1);
        end

        // Freeze ch0 with inc=0, then restart with inc=16.
        cfg(0, 0);
        while (cyc < 48) tick;
        check("freeze last pulse", clken[0], 1);
        for (int t = 49; t <= 52; t++) begin
            tick;
            check($sformatf("frozen clken c%0d", t), clken[0], 0);
            check($sformatf("frozen clkout c%0d", t), clkout[0], 0);
        end
        cfg(0, 16);
        check("inc0 pend ready", cfg_ready, 0);
        tick;
        check("inc0 apply ready", cfg_ready, 1);
        for (int t = 55; t <= 70; t++) begin
            tick;
            check($sformatf("inc16 clken c%0d", t), clken[0], (t == 70) ? 1 : 0);
            if (t == 61) check("inc16 clkout lo", clkout[0], 0);
            if (t == 62) check("inc16 clkout hi", clkout[0], 1);
        end

        // Sync: suppresses a due carry, applies pending immediately, forces clkout low.
        cfg(0, 3);
        sync = 1'b1;
        tick;
        sync = 1'b0;
        check("sync kills carry", clken, 0);
        check("sync clears pend", cfg_ready, 1);
        cfg(1, 5);
        check("ch1 pend ready", cfg_ready, 0);
        sync = 1'b1;
        tick;
        sync = 1'b0;
        check("sync clkout", clkout, 0);
        check("sync ready", cfg_ready, 1);
        while (cyc < 80) tick;
        sync = 1'b1;
        cfg(1, 7);
        sync = 1'b0;
        check("sync+cfg clken", clken, 0);
        check("sync+cfg clkout", clkout, 0);
        check("sync+cfg ready", cfg_ready, 1);
        first_pulse(1, 200, at);
        check("ch1 inc7 first", at, 118);
        first_pulse(0, 200, at);
        check("ch0 inc3 first", at, 167);
        while (cyc < 170) tick;
        check("locked after sync", locked, 1);

        // Out-of-range channel: accepted, no effect.
        cfg(7, 1);
        check("bad ch ready", cfg_ready, 1);
        tick;
        check("bad ch locked", locked, 1);
        first_pulse(1, 220, at);
        check("bad ch ch1 rate", at, 191);

        // Async reset while an update is pending.
        cfg(0, 100);
        check("pre-rst pend", cfg_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async ready", cfg_ready, 0);
        check("async locked", locked, 0);
        check("async clken", clken, 0);
        check("async clkout", clkout, 0);
        reset_and_lock("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
